// File: rtl/grade_board_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grade_board_if : teacher / principal / student command bundle            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
interface grade_board_if #(
  parameter int IDX_W  = 2,
  parameter int MARK_W = 8
);
  logic              t_wr_en;
  logic [IDX_W-1:0]  t_wr_idx;
  logic [MARK_W-1:0] t_wr_mark;
  logic              t_err;

  logic              p_appr_en;
  logic              p_ovr_en;
  logic [IDX_W-1:0]  p_idx;
  logic [MARK_W-1:0] p_mark;
  logic              p_err;
  logic              p_clr;

  logic              s_rd_req;
  logic [IDX_W-1:0]  s_rd_idx;
  logic              s_rd_valid;
  logic [MARK_W-1:0] s_rd_mark;
  logic              s_rd_pub;

  logic              all_pub;

  modport master (
    output t_wr_en, t_wr_idx, t_wr_mark,
    output p_appr_en, p_ovr_en, p_idx, p_mark, p_clr,
    output s_rd_req, s_rd_idx,
    input  t_err, p_err, s_rd_valid, s_rd_mark, s_rd_pub, all_pub
  );

  modport slave (
    input  t_wr_en, t_wr_idx, t_wr_mark,
    input  p_appr_en, p_ovr_en, p_idx, p_mark, p_clr,
    input  s_rd_req, s_rd_idx,
    output t_err, p_err, s_rd_valid, s_rd_mark, s_rd_pub, all_pub
  );
endinterface
`default_nettype wire

// File: rtl/grade_board.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grade_board : per-subject mark store with grade/approve/override flow    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module grade_board #(
  parameter int                  NUM_SUBJ = 3,
  parameter int                  MARK_W   = 8,
  parameter int                  MAX_MARK = 100,
  parameter logic [NUM_SUBJ-1:0] OVR_MASK = 3'b100,
  parameter int                  IDX_W    = (NUM_SUBJ > 1) ? $clog2(NUM_SUBJ) : 1
) (
  input wire logic     clk,
  input wire logic     rst_n,
  grade_board_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    GRADED   = 2'd1,
    APPROVED = 2'd2
  } subj_state_t;

  localparam logic [MARK_W-1:0] MAX_M = MARK_W'(MAX_MARK);

  function automatic logic [MARK_W-1:0] sat(input logic [MARK_W-1:0] m);
    return (m > MAX_M) ? MAX_M : m;
  endfunction

  logic                p_cmd;
  logic [NUM_SUBJ-1:0] t_ok;
  logic [NUM_SUBJ-1:0] p_ok;
  logic [NUM_SUBJ-1:0] appr_now;
  logic [NUM_SUBJ-1:0] appr_nxt;
  logic [MARK_W-1:0]   pub_mark [NUM_SUBJ];

  assign p_cmd = bus.p_appr_en | bus.p_ovr_en;

  for (genvar i = 0; i < NUM_SUBJ; i++) begin : g_subj
    subj_state_t       st_q, st_d;
    logic [MARK_W-1:0] mark_q, mark_d;
    logic              t_sel, p_sel, t_acc, p_acc;

    assign t_sel = bus.t_wr_en && (bus.t_wr_idx == IDX_W'(i));
    assign p_sel = (bus.p_idx == IDX_W'(i));

    // A principal command on the same subject always wins over the teacher.
    always_comb begin
      st_d   = st_q;
      mark_d = mark_q;
      t_acc  = 1'b0;
      p_acc  = 1'b0;
      if (bus.p_clr) begin
        st_d   = EMPTY;
        mark_d = '0;
      end else begin
        if (p_sel && bus.p_ovr_en) begin
          if (OVR_MASK[i] && (st_q != EMPTY)) begin
            st_d   = APPROVED;
            mark_d = sat(bus.p_mark);
            p_acc  = 1'b1;
          end
        end else if (p_sel && bus.p_appr_en) begin
          if (st_q == GRADED) begin
            st_d  = APPROVED;
            p_acc = 1'b1;
          end
        end
        if (t_sel && !(p_cmd && p_sel) && (st_q != APPROVED)) begin
          st_d   = GRADED;
          mark_d = sat(bus.t_wr_mark);
          t_acc  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st_q   <= EMPTY;
        mark_q <= '0;
      end else begin
        st_q   <= st_d;
        mark_q <= mark_d;
      end
    end

    assign t_ok[i]     = t_acc;
    assign p_ok[i]     = p_acc;
    assign appr_now[i] = (st_q == APPROVED);
    assign appr_nxt[i] = (st_d == APPROVED);
    assign pub_mark[i] = (st_q == APPROVED) ? mark_q : '0;
  end

  logic [MARK_W-1:0] rd_mark_sel;
  logic              rd_pub_sel;

  // Out-of-range indices match nothing and so read back as unpublished 0.
  always_comb begin
    rd_mark_sel = '0;
    rd_pub_sel  = 1'b0;
    for (int i = 0; i < NUM_SUBJ; i++) begin
      if (bus.s_rd_idx == IDX_W'(i)) begin
        rd_mark_sel = pub_mark[i];
        rd_pub_sel  = appr_now[i];
      end
    end
  end

  logic              t_err_q, p_err_q, rd_valid_q, rd_pub_q, all_pub_q;
  logic [MARK_W-1:0] rd_mark_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_err_q    <= 1'b0;
      p_err_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_mark_q  <= '0;
      rd_pub_q   <= 1'b0;
      all_pub_q  <= 1'b0;
    end else begin
      t_err_q    <= bus.t_wr_en && !bus.p_clr && !(|t_ok);
      p_err_q    <= p_cmd && !bus.p_clr && !(|p_ok);
      rd_valid_q <= bus.s_rd_req;
      rd_mark_q  <= bus.s_rd_req ? rd_mark_sel : '0;
      rd_pub_q   <= bus.s_rd_req && rd_pub_sel;
      all_pub_q  <= &appr_nxt;
    end
  end

  assign bus.t_err      = t_err_q;
  assign bus.p_err      = p_err_q;
  assign bus.s_rd_valid = rd_valid_q;
  assign bus.s_rd_mark  = rd_mark_q;
  assign bus.s_rd_pub   = rd_pub_q;
  assign bus.all_pub    = all_pub_q;

endmodule
`default_nettype wire

// File: tb/tb_grade_board.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grade_board : directed table, corner sequence and random vs model     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_grade_board;
  localparam int         NS   = 3;
  localparam int         MW   = 8;
  localparam int         IW   = 2;
  localparam int         MAXM = 100;
  localparam logic [2:0] MASK = 3'b100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grade_board_if #(.IDX_W(IW), .MARK_W(MW)) bus ();

  grade_board #(
    .NUM_SUBJ(NS), .MARK_W(MW), .MAX_MARK(MAXM), .OVR_MASK(MASK), .IDX_W(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int r, input int twe, input int tidx, input int tmk,
                       input int ap, input int ov, input int pidx, input int pmk,
                       input int clr, input int rd, input int ridx);
    rst_n         = 1'(r);
    bus.t_wr_en   = 1'(twe);
    bus.t_wr_idx  = IW'(tidx);
    bus.t_wr_mark = MW'(tmk);
    bus.p_appr_en = 1'(ap);
    bus.p_ovr_en  = 1'(ov);
    bus.p_idx     = IW'(pidx);
    bus.p_mark    = MW'(pmk);
    bus.p_clr     = 1'(clr);
    bus.s_rd_req  = 1'(rd);
    bus.s_rd_idx  = IW'(ridx);
  endtask

  // Reference model: 0=empty, 1=graded, 2=approved.
  int m_st [NS];
  int m_mk [NS];
  int e_terr, e_perr, e_valid, e_mark, e_pub, e_all;

  function automatic int sat(input int m);
    return (m > MAXM) ? MAXM : m;
  endfunction

  function automatic void model_step();
    int ti, pi, ri;
    logic pcmd;
    ti = int'(bus.t_wr_idx);
    pi = int'(bus.p_idx);
    ri = int'(bus.s_rd_idx);
    if (!rst_n) begin
      foreach (m_st[k]) begin m_st[k] = 0; m_mk[k] = 0; end
      e_terr = 0; e_perr = 0; e_valid = 0; e_mark = 0; e_pub = 0; e_all = 0;
      return;
    end
    e_valid = int'(bus.s_rd_req);
    e_pub   = (bus.s_rd_req && ri < NS && m_st[ri] == 2) ? 1 : 0;
    e_mark  = e_pub ? m_mk[ri] : 0;
    e_terr  = 0;
    e_perr  = 0;
    if (bus.p_clr) begin
      foreach (m_st[k]) begin m_st[k] = 0; m_mk[k] = 0; end
    end else begin
      pcmd = bus.p_appr_en | bus.p_ovr_en;
      if (bus.p_ovr_en) begin
        if (pi < NS && MASK[pi] && m_st[pi] != 0) begin
          m_st[pi] = 2; m_mk[pi] = sat(int'(bus.p_mark));
        end else e_perr = 1;
      end else if (bus.p_appr_en) begin
        if (pi < NS && m_st[pi] == 1) m_st[pi] = 2;
        else e_perr = 1;
      end
      if (bus.t_wr_en) begin
        if (ti >= NS || (pcmd && pi == ti) || m_st[ti] == 2) e_terr = 1;
        else begin m_st[ti] = 1; m_mk[ti] = sat(int'(bus.t_wr_mark)); end
      end
    end
    e_all = 1;
    foreach (m_st[k]) if (m_st[k] != 2) e_all = 0;
  endfunction

  task automatic step_check_model(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".t_err"}, 32'(bus.t_err), 32'(e_terr));
    chk({tag, ".p_err"}, 32'(bus.p_err), 32'(e_perr));
    chk({tag, ".valid"}, 32'(bus.s_rd_valid), 32'(e_valid));
    chk({tag, ".all_pub"}, 32'(bus.all_pub), 32'(e_all));
    if (e_valid != 0) begin
      chk({tag, ".mark"}, 32'(bus.s_rd_mark), 32'(e_mark));
      chk({tag, ".pub"}, 32'(bus.s_rd_pub), 32'(e_pub));
    end
  endtask

  typedef struct {
    int r, twe, tidx, tmk, ap, ov, pidx, pmk, clr, rd, ridx;
    int terr, perr, val, mark, pub, all;
  } vec_t;

  function automatic vec_t v(input int r, twe, tidx, tmk, ap, ov, pidx, pmk, clr, rd, ridx,
                             input int terr, perr, val, mark, pub, all);
    vec_t x;
    x.r = r; x.twe = twe; x.tidx = tidx; x.tmk = tmk; x.ap = ap; x.ov = ov;
    x.pidx = pidx; x.pmk = pmk; x.clr = clr; x.rd = rd; x.ridx = ridx;
    x.terr = terr; x.perr = perr; x.val = val; x.mark = mark; x.pub = pub; x.all = all;
    return x;
  endfunction

  vec_t tbl [$];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //          r twe ti tmk ap ov pi pmk clr rd ri | terr perr val mark pub all
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 1, 0,  85, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 1, 1,  90, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 1, 2,  95, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 1,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 2,   0, 0, 0, 0,  0, 0, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1,  0, 0, 1,  90, 1, 1));
    tbl.push_back(v(1, 1, 1,  70, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1,  0, 0, 1,  90, 1, 1));
    tbl.push_back(v(1, 1, 0,  60, 0, 0, 0,   0, 1, 1, 0,  0, 0, 1,  85, 1, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 1,   0, 0, 0));
    tbl.push_back(v(1, 1, 1, 120, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 1, 0,  85, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 1, 0,  50, 0, 0, 0,  0, 1, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 1,   0, 0, 0));
    tbl.push_back(v(1, 1, 1,  70, 1, 0, 1,   0, 0, 0, 0,  1, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1,  0, 0, 1, 100, 1, 0));
    tbl.push_back(v(1, 1, 2,  95, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2,  0, 0, 1,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 1, 2,  99, 0, 0, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2,  0, 0, 1,  99, 1, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 3,  0, 0, 1,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 3,   0, 0, 0, 0,  0, 1, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 1, 1, 2, 200, 0, 0, 0,  0, 0, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2,  0, 0, 1, 100, 1, 1));
    tbl.push_back(v(1, 1, 3,  10, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 1, 0, 0,   0, 0, 0, 0,  0, 1, 0,   0, 0, 1));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 1,  85, 1, 1));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 1,   0, 0, 0));

    foreach (tbl[n]) begin
      vec_t x;
      string tag;
      x = tbl[n];
      tag = $sformatf("row%0d", n);
      drive(x.r, x.twe, x.tidx, x.tmk, x.ap, x.ov, x.pidx, x.pmk, x.clr, x.rd, x.ridx);
      @(posedge clk);
      model_step();
      #1;
      chk({tag, ".t_err"}, 32'(bus.t_err), 32'(x.terr));
      chk({tag, ".p_err"}, 32'(bus.p_err), 32'(x.perr));
      chk({tag, ".valid"}, 32'(bus.s_rd_valid), 32'(x.val));
      chk({tag, ".all_pub"}, 32'(bus.all_pub), 32'(x.all));
      if (x.val != 0) begin
        chk({tag, ".mark"}, 32'(bus.s_rd_mark), 32'(x.mark));
        chk({tag, ".pub"}, 32'(bus.s_rd_pub), 32'(x.pub));
      end
    end

    // Back-to-back reads: one response per cycle, each tracking its own index.
    drive(1, 1, 0, 40, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); model_step(); #1;
    chk("b2b0.valid", 32'(bus.s_rd_valid), 32'd1);
    chk("b2b0.mark", 32'(bus.s_rd_mark), 32'd40);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); model_step(); #1;
    chk("b2b1.valid", 32'(bus.s_rd_valid), 32'd1);
    chk("b2b1.pub", 32'(bus.s_rd_pub), 32'd0);
    chk("b2b1.mark", 32'(bus.s_rd_mark), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); model_step(); #1;
    chk("b2b2.valid", 32'(bus.s_rd_valid), 32'd1);
    chk("b2b2.mark", 32'(bus.s_rd_mark), 32'd40);
    chk("b2b2.pub", 32'(bus.s_rd_pub), 32'd1);

    for (int c = 0; c < 600; c++) begin
      int mk_t, mk_p;
      mk_t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(101, 255)) : int'($urandom_range(0, 100));
      mk_p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(101, 255)) : int'($urandom_range(0, 100));
      drive(($urandom_range(0, 79) == 0) ? 0 : 1,
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), mk_t,
            ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)), mk_p,
            ($urandom_range(0, 49) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      step_check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
